// File: rtl/alu_writeback_if.sv
// Byte-wide memory write bus leaving the writeback stage.
// A beat transfers on a rising edge where mem_valid && mem_ready; once raised, mem_valid,
// mem_addr and mem_wdata hold steady until that edge, and mem_ready is ignored while mem_valid=0.
interface alu_writeback_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
    modport slave  (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage after the f8 ALU: registered register-file write, byte-serial
// little-endian memory write, C/Z/N flag update and a retired-instruction counter.
module alu_writeback (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           result_reg,
    input  logic [15:0]           result_mem,
    input  logic                  z_in,
    input  logic                  n_in,
    input  logic                  c_in,
    input  logic                  wide,
    input  logic                  wr_reg,
    input  logic [2:0]            reg_addr,
    input  logic                  wr_mem,
    input  logic [15:0]           mem_addr_in,
    input  logic [2:0]            flags_we,
    output logic                  rf_we,
    output logic                  rf_wide,
    output logic [2:0]            rf_addr,
    output logic [15:0]           rf_wdata,
    alu_writeback_if.master       mem,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic [15:0]           retire_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_LO = 2'd1,
        MEM_HI = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        wide_q, wide_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rf_we_q, rf_we_d;
    logic        rf_wide_q, rf_wide_d;
    logic [2:0]  rf_addr_q, rf_addr_d;
    logic [15:0] rf_wdata_q, rf_wdata_d;
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;
    logic [15:0] retire_q, retire_d;

    logic accept;
    logic retire_inc;

    always_comb begin
        state_d    = state_q;
        wide_d     = wide_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rf_we_d    = 1'b0;
        rf_wide_d  = rf_wide_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        retire_inc = 1'b0;
        accept     = in_valid && (state_q == IDLE);

        if (accept) begin
            if (flags_we[2]) flag_c_d = c_in;
            if (flags_we[1]) flag_z_d = z_in;
            if (flags_we[0]) flag_n_d = n_in;
            if (wr_reg) begin
                rf_we_d    = 1'b1;
                rf_wide_d  = wide;
                rf_addr_d  = reg_addr;
                rf_wdata_d = wide ? result_reg : {8'h00, result_reg[7:0]};
            end
            if (wr_mem) begin
                wide_d = wide;
                addr_d = mem_addr_in;
                data_d = result_mem;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wr_mem) state_d = MEM_LO;
                    else        retire_inc = 1'b1;
                end
            end
            MEM_LO: begin
                if (mem.mem_ready) begin
                    if (wide_q) begin
                        state_d = MEM_HI;
                    end else begin
                        state_d    = IDLE;
                        retire_inc = 1'b1;
                    end
                end
            end
            MEM_HI: begin
                if (mem.mem_ready) begin
                    state_d    = IDLE;
                    retire_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        retire_d = retire_inc ? retire_q + 16'd1 : retire_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wide_q     <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            rf_we_q    <= 1'b0;
            rf_wide_q  <= 1'b0;
            rf_addr_q  <= 3'd0;
            rf_wdata_q <= 16'h0000;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            retire_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wide_q     <= wide_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rf_we_q    <= rf_we_d;
            rf_wide_q  <= rf_wide_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            retire_q   <= retire_d;
        end
    end

    // Beat outputs decode straight from state so reset drops mem_valid without waiting for a clock.
    assign in_ready      = (state_q == IDLE);
    assign mem.mem_valid = (state_q != IDLE);
    assign mem.mem_addr  = (state_q == MEM_HI) ? addr_q + 16'd1 : addr_q;
    assign mem.mem_wdata = (state_q == MEM_HI) ? data_q[15:8] : data_q[7:0];

    assign rf_we        = rf_we_q;
    assign rf_wide      = rf_wide_q;
    assign rf_addr      = rf_addr_q;
    assign rf_wdata     = rf_wdata_q;
    assign flag_c       = flag_c_q;
    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;
    assign retire_count = retire_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: inputs are driven and outputs checked on the falling edge.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result_reg, result_mem;
    logic        z_in, n_in, c_in, wide, wr_reg, wr_mem;
    logic [2:0]  reg_addr;
    logic [15:0] mem_addr_in;
    logic [2:0]  flags_we;
    logic        rf_we, rf_wide;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic        flag_c, flag_z, flag_n;
    logic [15:0] retire_count;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_retire;

    alu_writeback_if mem_if ();

    alu_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result_reg   (result_reg),
        .result_mem   (result_mem),
        .z_in         (z_in),
        .n_in         (n_in),
        .c_in         (c_in),
        .wide         (wide),
        .wr_reg       (wr_reg),
        .reg_addr     (reg_addr),
        .wr_mem       (wr_mem),
        .mem_addr_in  (mem_addr_in),
        .flags_we     (flags_we),
        .rf_we        (rf_we),
        .rf_wide      (rf_wide),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .mem          (mem_if),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .retire_count (retire_count),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        in_valid = 1'b0; wr_reg = 1'b0; wr_mem = 1'b0; wide = 1'b0;
        flags_we = 3'b000; reg_addr = 3'd0; result_reg = 16'h0; result_mem = 16'h0;
        mem_addr_in = 16'h0; c_in = 1'b0; z_in = 1'b0; n_in = 1'b0;
    endtask

    task automatic drive_inst(input logic w, input logic wr_r, input logic [2:0] ra,
                              input logic [15:0] rr, input logic wr_m, input logic [15:0] ma,
                              input logic [15:0] rm, input logic [2:0] fwe,
                              input logic c, input logic z, input logic n);
        in_valid = 1'b1; wide = w; wr_reg = wr_r; reg_addr = ra; result_reg = rr;
        wr_mem = wr_m; mem_addr_in = ma; result_mem = rm; flags_we = fwe;
        c_in = c; z_in = z; n_in = n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        mem_if.mem_ready = 1'b0;
        exp_retire = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, rf_we, rf_wide, rf_addr, rf_wdata} !== {1'b1, 1'b0, 1'b0, 3'd0, 16'h0000})
            $display("FAIL reset_rf got %h exp %h", {in_ready, rf_we, rf_wide, rf_addr, rf_wdata}, 22'h200000);
        else passes++;
        checks++;
        if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata} !== 25'h0)
            $display("FAIL reset_mem got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata}, 25'h0);
        else passes++;
        checks++;
        if ({flag_c, flag_z, flag_n, retire_count, dbg_state} !== 21'h0)
            $display("FAIL reset_flags got %h exp %h", {flag_c, flag_z, flag_n, retire_count, dbg_state}, 21'h0);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, dbg_state} !== 3'b100)
            $display("FAIL reset_release got %b exp %b", {in_ready, dbg_state}, 3'b100);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] dat [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        drive_inst(1'b0, 1'b1, 3'd1, {8'hAB, dat[0]}, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, in_ready);
            else passes++;
            @(negedge clk);
            checks++;
            if ({rf_we, rf_wide, rf_addr, rf_wdata} !== {1'b1, 1'b0, 3'(i + 1), 8'h00, dat[i]})
                $display("FAIL b2b_rf%0d got %h exp %h", i, {rf_we, rf_wide, rf_addr, rf_wdata},
                         {1'b1, 1'b0, 3'(i + 1), 8'h00, dat[i]});
            else passes++;
            if (i < 2) begin
                reg_addr = 3'(i + 2);
                result_reg = {8'hAB, dat[i + 1]};
            end
        end
        drive_idle();
        exp_retire = exp_retire + 16'd3;
        @(negedge clk);
        checks++;
        if ({rf_we, retire_count} !== {1'b0, exp_retire})
            $display("FAIL b2b_retire got %h exp %h", {rf_we, retire_count}, {1'b0, exp_retire});
        else passes++;
    endtask

    task automatic test_flags();
        drive_inst(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'h0, 3'b100, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if ({flag_c, flag_z, flag_n} !== 3'b100)
            $display("FAIL flags_c_only got %b exp %b", {flag_c, flag_z, flag_n}, 3'b100);
        else passes++;
        drive_inst(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'h0, 3'b010, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({flag_c, flag_z, flag_n} !== 3'b110)
            $display("FAIL flags_z_only got %b exp %b", {flag_c, flag_z, flag_n}, 3'b110);
        else passes++;
        drive_idle();
        flags_we = 3'b111;
        @(negedge clk);
        checks++;
        if ({flag_c, flag_z, flag_n} !== 3'b110)
            $display("FAIL flags_hold got %b exp %b", {flag_c, flag_z, flag_n}, 3'b110);
        else passes++;
        drive_idle();
        exp_retire = exp_retire + 16'd2;
        checks++;
        if (retire_count !== exp_retire) $display("FAIL flags_retire got %h exp %h", retire_count, exp_retire);
        else passes++;
    endtask

    task automatic test_wide_mem();
        drive_inst(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 16'hFFFF, 16'hA55A, 3'b000, 1'b0, 1'b0, 1'b0);
        mem_if.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) drive_idle();
            checks++;
            if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, in_ready, retire_count} !==
                {1'b1, 16'hFFFF, 8'h5A, 1'b0, exp_retire})
                $display("FAIL wide_lo%0d got %h exp %h", k,
                         {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, in_ready, retire_count},
                         {1'b1, 16'hFFFF, 8'h5A, 1'b0, exp_retire});
            else passes++;
            if (k == 2) mem_if.mem_ready = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) mem_if.mem_ready = 1'b0;
            checks++;
            if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, in_ready, retire_count} !==
                {1'b1, 16'h0000, 8'hA5, 1'b0, exp_retire})
                $display("FAIL wide_hi%0d got %h exp %h", k,
                         {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, in_ready, retire_count},
                         {1'b1, 16'h0000, 8'hA5, 1'b0, exp_retire});
            else passes++;
            if (k == 2) mem_if.mem_ready = 1'b1;
        end
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        exp_retire = exp_retire + 16'd1;
        checks++;
        if ({mem_if.mem_valid, in_ready, retire_count} !== {1'b0, 1'b1, exp_retire})
            $display("FAIL wide_done got %h exp %h", {mem_if.mem_valid, in_ready, retire_count},
                     {1'b0, 1'b1, exp_retire});
        else passes++;
    endtask

    task automatic test_exchange();
        drive_inst(1'b0, 1'b1, 3'd5, 16'h00C3, 1'b1, 16'h0100, 16'h0044, 3'b000, 1'b0, 1'b0, 1'b0);
        mem_if.mem_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        checks++;
        if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 3'd5, 16'h00C3})
            $display("FAIL xchg_rf got %h exp %h", {rf_we, rf_addr, rf_wdata}, {1'b1, 3'd5, 16'h00C3});
        else passes++;
        checks++;
        if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, retire_count} !==
            {1'b1, 16'h0100, 8'h44, exp_retire})
            $display("FAIL xchg_beat got %h exp %h",
                     {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, retire_count},
                     {1'b1, 16'h0100, 8'h44, exp_retire});
        else passes++;
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        exp_retire = exp_retire + 16'd1;
        checks++;
        if ({rf_we, mem_if.mem_valid, in_ready, retire_count} !== {1'b0, 1'b0, 1'b1, exp_retire})
            $display("FAIL xchg_done got %h exp %h", {rf_we, mem_if.mem_valid, in_ready, retire_count},
                     {1'b0, 1'b0, 1'b1, exp_retire});
        else passes++;
    endtask

    task automatic test_retire_wrap();
        int need;
        need = 16'hFFFF - exp_retire;
        drive_inst(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (need) @(negedge clk);
        checks++;
        if (retire_count !== 16'hFFFF) $display("FAIL wrap_max got %h exp ffff", retire_count);
        else passes++;
        @(negedge clk);
        drive_idle();
        checks++;
        if (retire_count !== 16'h0000) $display("FAIL wrap_zero got %h exp 0000", retire_count);
        else passes++;
    endtask

    task automatic test_reset_mid_write();
        drive_inst(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 16'h1234, 16'hBEEF, 3'b111, 1'b1, 1'b1, 1'b1);
        mem_if.mem_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        checks++;
        if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, flag_c, flag_z, flag_n} !==
            {1'b1, 16'h1234, 8'hEF, 3'b111})
            $display("FAIL rst_mid_lo got %h exp %h",
                     {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, flag_c, flag_z, flag_n},
                     {1'b1, 16'h1234, 8'hEF, 3'b111});
        else passes++;
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        checks++;
        if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, dbg_state} !== {1'b1, 16'h1235, 8'hBE, 2'd2})
            $display("FAIL rst_mid_hi got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata, dbg_state},
                     {1'b1, 16'h1235, 8'hBE, 2'd2});
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_if.mem_valid !== 1'b0) $display("FAIL rst_async_valid got %b exp 0", mem_if.mem_valid);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({dbg_state, in_ready, mem_if.mem_valid, flag_c, flag_z, flag_n, retire_count} !==
            {2'd0, 1'b1, 1'b0, 3'b000, 16'h0000})
            $display("FAIL rst_after got %h exp %h",
                     {dbg_state, in_ready, mem_if.mem_valid, flag_c, flag_z, flag_n, retire_count},
                     {2'd0, 1'b1, 1'b0, 3'b000, 16'h0000});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flags();
        test_wide_mem();
        test_exchange();
        test_retire_wrap();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the f8 ALU. Captures one ALU result per accepted instruction and commits it: a registered write to the register file, a byte-serial memory write over an 8-bit valid/ready bus, and an update of the C/Z/N flag register that feeds the ALU carry input. Stalls the upstream pipeline while a memory write is outstanding.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage can accept; in_valid && in_ready = accept.
- result_reg  in  16  ALU result for the register file.
- result_mem  in  16  ALU result for memory.
- z_in, n_in, c_in  in  1 each  ALU flag outputs.
- wide  in  1  16-bit result (1) or 8-bit result (0).
- wr_reg  in  1  commit result_reg to the register file.
- reg_addr  in  3  destination register index.
- wr_mem  in  1  commit result_mem to memory.
- mem_addr_in  in  16  destination byte address.
- flags_we  in  3  per-flag update mask: [2]=C, [1]=Z, [0]=N.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_wide  out  1  register-file write width.
- rf_addr  out  3  register-file write index.
- rf_wdata  out  16  register-file write data; bits [15:8] zero when rf_wide=0.
- mem_valid  out  1  memory write beat presented.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  16  beat byte address.
- mem_wdata  out  8  beat data.
- flag_c, flag_z, flag_n  out  1 each  architectural flags; flag_c drives ALU c_in.
- retire_count  out  16  instructions retired, wraps modulo 2^16.

## Operation
- States: IDLE, MEM_LO, MEM_HI.
- in_ready = 1 only in IDLE (combinational from state).
- On accept: capture wide, wr_reg, reg_addr, result_reg, wr_mem, mem_addr_in, result_mem.
- Flags: on accept, each flag with its flags_we bit set loads the corresponding ALU flag; others hold. Flags never change outside an accept edge.
- Register write: if wr_reg, rf_we = 1 for exactly the cycle after accept, with rf_addr, rf_wide, rf_wdata from the captured values. Independent of any memory activity.
- Memory write, little-endian: if wr_mem, go to MEM_LO: mem_valid=1, mem_addr=captured address, mem_wdata=result_mem[7:0]. On mem_ready: wide → MEM_HI, else → IDLE. MEM_HI: mem_addr = address+1 (16-bit wrap, 0xFFFF+1 = 0x0000), mem_wdata = result_mem[15:8]; on mem_ready → IDLE.
- mem_valid, mem_addr, mem_wdata remain stable while mem_valid=1 and mem_ready=0.
- Accept without wr_mem: stay IDLE; back-to-back accepts every cycle allowed.
- wr_reg and wr_mem together (exchange instructions): both performed; rf_we still fires the cycle after accept.
- Retire: retire_count increments once per instruction: on the accept edge if wr_mem=0, else on the edge completing the final memory beat.
- Accept with wr_reg=0, wr_mem=0, flags_we=0 still retires.

## Timing
- Reset values: state IDLE, in_ready 1, rf_we 0, rf_wide 0, rf_addr 0, rf_wdata 0, mem_valid 0, mem_addr 0, mem_wdata 0, flags 0, retire_count 0.
- Reset asserted mid-write: mem_valid drops asynchronously; the partial write is abandoned; no retire.
- Flag latency: flags updated at accept edge; the next instruction accepted one cycle later sees the new flag_c.
- Register-file write latency: 1 cycle after accept.
- Memory latency: 8-bit write occupies ≥1 cycle in MEM_LO; 16-bit write ≥2 cycles; in_ready returns in the cycle after the final handshake.
- mem_ready while mem_valid=0 is ignored.

## Test plan
- Reset mid-MEM_HI (addr 0x1234, data 0xBEEF) → mem_valid 0 immediately; after release state IDLE, flags 0, retire_count 0.
- Three back-to-back accepts, wr_reg=1, reg_addr 1,2,3, 8-bit data 0x11,0x22,0x33 → rf_we high three consecutive cycles, correct addr/data, in_ready constantly 1, retire_count 3.
- wide wr_mem, addr 0xFFFF, data 0xA55A, mem_ready held low 2 cycles per beat → beat 0xFFFF/0x5A then 0x0000/0xA5, stable during stalls, in_ready 0 until after second handshake.
- Exchange: wr_reg=1, wr_mem=1, result_reg 0x00C3, result_mem 0x0044, 8-bit → rf_we next cycle with 0xC3; memory beat 0x44; retire once, at beat.
- Flag masking: flags 0; accept c=1,z=1,n=1 with flags_we=3'b100 → only flag_c=1; next accept c=0,z=1 with 3'b010 → flag_c 1, flag_z 1.
- retire_count at 0xFFFF plus one non-memory accept → 0x0000.
